// File: rtl/main_ram_arbiter_pkg.sv
// Shared widths, request payload type and round-robin pointer helper for main_ram_arbiter.
package main_ram_arbiter_pkg;

  localparam int MRA_ADDR_W = 15;
  localparam int MRA_DATA_W = 32;
  localparam int MRA_BE_W   = 4;

  typedef struct packed {
    logic                  write;
    logic [MRA_ADDR_W-1:0] addr;
    logic [MRA_DATA_W-1:0] wrdata;
    logic [MRA_BE_W-1:0]   bytesel;
  } mra_req_t;

  // Pointer advance after granting port g; ports 1..nports-1 form the ring.
  function automatic int rr_next(input int g, input int nports);
    return (g == nports - 1) ? 1 : g + 1;
  endfunction

endpackage

// File: rtl/main_ram_arbiter_rr_pick.sv
// Rotating-mask priority encoder: lowest set request at or above start, else lowest set request overall.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  logic [N-1:0] masked_s;
  logic [N-1:0] sel_s;

  // Pick the lowest index in the masked set, falling back to the full set to wrap.
  always_comb begin
    masked_s = req & ({N{1'b1}} << start);
    sel_s    = '0;
    idx      = '0;
    if (|masked_s) begin
      sel_s = masked_s;
    end else begin
      sel_s = req;
    end
    for (int i = N - 1; i >= 0; i--) begin
      idx = sel_s[i] ? IW'(i) : idx;
    end
    any   = |req;
    grant = any ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/main_ram_arbiter.sv
// Single-port main_ram arbiter: port 0 absolute priority, ports 1..N-1 fixed priority or,
// with MAIN_RAM_ARB_RR_EN defined, round-robin. One access per clk, read data one cycle later.
module main_ram_arbiter
  import main_ram_arbiter_pkg::*;
#(
  parameter int NPORTS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NPORTS-1:0]            req,
  input  logic [NPORTS-1:0]            req_write,
  input  logic [NPORTS*MRA_ADDR_W-1:0] req_addr,
  input  logic [NPORTS*MRA_DATA_W-1:0] req_wrdata,
  input  logic [NPORTS*MRA_BE_W-1:0]   req_bytesel,
  output logic [NPORTS-1:0]            ack,
  output logic [NPORTS-1:0]            rd_valid,
  output logic [MRA_DATA_W-1:0]        rd_data,
  output logic [MRA_ADDR_W-1:0]        bus_addr,
  output logic [MRA_DATA_W-1:0]        bus_wrdata,
  output logic [MRA_BE_W-1:0]          bus_wrbytesel,
  output logic                         bus_write,
  input  logic [MRA_DATA_W-1:0]        bus_rddata
);

  localparam int IW = $clog2(NPORTS);

  if (NPORTS < 2 || NPORTS > 8) begin : g_bad_nports
    $error("main_ram_arbiter: NPORTS must be in 2..8");
  end

  logic [NPORTS-1:0]     cand_s;
  logic [IW-1:0]         start_s;
  logic [NPORTS-1:0]     pick_grant_s;
  logic [IW-1:0]         pick_idx_s;
  logic                  pick_any_s;
  logic [NPORTS-1:0]     gnt_s;
  logic [IW-1:0]         gidx_s;
  logic                  gvld_s;
  mra_req_t              sel_s;
  logic [NPORTS-1:0]     rd_valid_r;
  logic [MRA_ADDR_W-1:0] last_addr_r;

  assign cand_s = {req[NPORTS-1:1], 1'b0};

`ifdef MAIN_RAM_ARB_RR_EN
  logic [IW-1:0] rr_ptr_r;
  assign start_s = rr_ptr_r;

  // Round-robin pointer; port-0 grants leave it where it is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_r <= IW'(1);
    end else if (gvld_s && (gidx_s != '0)) begin
      rr_ptr_r <= IW'(rr_next(int'(gidx_s), NPORTS));
    end else begin
      rr_ptr_r <= rr_ptr_r;
    end
  end
`else
  assign start_s = IW'(1);
`endif

  rr_pick #(.N(NPORTS), .IW(IW)) u_rr_pick (
    .req   (cand_s),
    .start (start_s),
    .grant (pick_grant_s),
    .idx   (pick_idx_s),
    .any   (pick_any_s)
  );

  // Grant selection; nothing is granted while reset is held.
  always_comb begin
    gnt_s  = '0;
    gidx_s = '0;
    gvld_s = 1'b0;
    if (!rst_n) begin
      gvld_s = 1'b0;
    end else if (req[0]) begin
      gnt_s  = NPORTS'(1);
      gvld_s = 1'b1;
    end else if (pick_any_s) begin
      gnt_s  = pick_grant_s;
      gidx_s = pick_idx_s;
      gvld_s = 1'b1;
    end else begin
      gvld_s = 1'b0;
    end
  end

  // Payload mux for the granted port.
  always_comb begin
    sel_s = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (gidx_s == IW'(i)) begin
        sel_s.write   = req_write[i];
        sel_s.addr    = req_addr[i*MRA_ADDR_W +: MRA_ADDR_W];
        sel_s.wrdata  = req_wrdata[i*MRA_DATA_W +: MRA_DATA_W];
        sel_s.bytesel = req_bytesel[i*MRA_BE_W +: MRA_BE_W];
      end else begin
        sel_s = sel_s;
      end
    end
  end

  // Bus drive; an idle cycle is a harmless read of the previous address.
  always_comb begin
    bus_addr      = last_addr_r;
    bus_wrdata    = '0;
    bus_wrbytesel = '0;
    bus_write     = 1'b0;
    if (gvld_s) begin
      bus_addr      = sel_s.addr;
      bus_wrdata    = sel_s.wrdata;
      bus_wrbytesel = sel_s.bytesel;
      bus_write     = sel_s.write;
    end else begin
      bus_write     = 1'b0;
    end
  end

  // Read-return tag and held address; reset drops any read still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_valid_r  <= '0;
      last_addr_r <= '0;
    end else begin
      rd_valid_r  <= gnt_s & {NPORTS{~sel_s.write}};
      last_addr_r <= bus_addr;
    end
  end

  assign ack      = gnt_s;
  assign rd_valid = rd_valid_r;
  assign rd_data  = bus_rddata;

endmodule

// File: tb/tb_main_ram_arbiter.sv
// Self-checking bench for main_ram_arbiter (NPORTS=4) with a behavioural SPRAM and reference model.
module tb_main_ram_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_write = '0;
  logic [N*15-1:0] req_addr = '0;
  logic [N*32-1:0] req_wrdata = '0;
  logic [N*4-1:0]  req_bytesel = '0;
  logic [N-1:0]    ack;
  logic [N-1:0]    rd_valid;
  logic [31:0]     rd_data;
  logic [14:0]     bus_addr;
  logic [31:0]     bus_wrdata;
  logic [3:0]      bus_wrbytesel;
  logic            bus_write;
  logic [31:0]     bus_rddata = '0;

  int n_checks = 0;
  int n_fail   = 0;

  main_ram_arbiter #(.NPORTS(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req           (req),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wrdata    (req_wrdata),
    .req_bytesel   (req_bytesel),
    .ack           (ack),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .bus_addr      (bus_addr),
    .bus_wrdata    (bus_wrdata),
    .bus_wrbytesel (bus_wrbytesel),
    .bus_write     (bus_write),
    .bus_rddata    (bus_rddata)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_val(input logic [14:0] a);
    return {a, a, 2'b01} ^ 32'hA5C3_0F69;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Behavioural single-port RAM with registered read.
  logic [31:0] ram_mem [0:32767];
  bit          ram_vld [0:32767];
  always @(posedge clk) begin
    if (bus_write) begin
      ram_mem[bus_addr] <= merge(ram_vld[bus_addr] ? ram_mem[bus_addr] : init_val(bus_addr), bus_wrdata, bus_wrbytesel);
      ram_vld[bus_addr] <= 1'b1;
    end else begin
      bus_rddata <= ram_vld[bus_addr] ? ram_mem[bus_addr] : init_val(bus_addr);
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [0:32767];
  bit          ref_vld [0:32767];
  int          m_ptr = 1;
  bit          m_pend = 1'b0;
  int          m_pend_port = 0;
  logic [31:0] m_pend_data = '0;
  logic [14:0] m_last_addr = '0;
  int          m_win = -1;

  function automatic logic [14:0] addr_of(input int p);
    return req_addr[15*p +: 15];
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    int p;
    if (r[0]) return 0;
    for (int k = 0; k < N - 1; k++) begin
      p = 1 + ((ptr - 1 + k) % (N - 1));
      if (r[p]) return p;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_port(input int p, input logic r, input logic w, input logic [14:0] a,
                          input logic [31:0] d, input logic [3:0] be);
    req[p]               = r;
    req_write[p]         = w;
    req_addr[15*p +: 15] = a;
    req_wrdata[32*p +: 32] = d;
    req_bytesel[4*p +: 4]  = be;
  endtask

  // Compare all DUT outputs against the model at the falling edge.
  task automatic chk_cycle();
    logic [N-1:0] exp_ack;
    logic [N-1:0] exp_rdv;
    logic         exp_wr;
    @(negedge clk);
    m_win   = rst_n ? pick(req, m_ptr) : -1;
    exp_ack = (m_win >= 0) ? (N'(1) << m_win) : '0;
    exp_wr  = (m_win >= 0) ? req_write[m_win] : 1'b0;
    check("ack", 64'(ack), 64'(exp_ack));
    check("bus_write", 64'(bus_write), 64'(exp_wr));
    check("bus_addr", 64'(bus_addr), !rst_n ? 64'd0 : (m_win >= 0) ? 64'(addr_of(m_win)) : 64'(m_last_addr));
    if (exp_wr) begin
      check("bus_wrdata", 64'(bus_wrdata), 64'(req_wrdata[32*m_win +: 32]));
      check("bus_wrbytesel", 64'(bus_wrbytesel), 64'(req_bytesel[4*m_win +: 4]));
    end
    exp_rdv = (rst_n && m_pend) ? (N'(1) << m_pend_port) : '0;
    check("rd_valid", 64'(rd_valid), 64'(exp_rdv));
    if (exp_rdv != '0) check("rd_data", 64'(rd_data), 64'(m_pend_data));
  endtask

  // Advance the model across the rising edge, then step off it.
  task automatic adv();
    logic [14:0] a;
    @(posedge clk);
    if (!rst_n) begin
      m_ptr = 1; m_pend = 1'b0; m_last_addr = '0;
    end else begin
      m_pend = 1'b0;
      if (m_win >= 0) begin
        a = addr_of(m_win);
        m_last_addr = a;
        if (req_write[m_win]) begin
          ref_mem[a] = merge(ref_vld[a] ? ref_mem[a] : init_val(a), req_wrdata[32*m_win +: 32], req_bytesel[4*m_win +: 4]);
          ref_vld[a] = 1'b1;
        end else begin
          m_pend = 1'b1; m_pend_port = m_win;
          m_pend_data = ref_vld[a] ? ref_mem[a] : init_val(a);
        end
`ifdef MAIN_RAM_ARB_RR_EN
        if (m_win >= 1) m_ptr = (m_win == N - 1) ? 1 : m_win + 1;
`endif
      end
    end
    #1;
  endtask

  task automatic clear_all();
    for (int p = 0; p < N; p++) set_port(p, 1'b0, 1'b0, 15'h0, 32'h0, 4'h0);
  endtask

  initial begin
    logic [31:0] iv;
    int          seq [6];
    bit          p0;

    // Reset held with every port requesting.
    for (int p = 0; p < N; p++) set_port(p, 1'b1, 1'b0, 15'(16'h0200 + p), 32'h0, 4'hF);
    adv();
    chk_cycle();
    check("reset_ack", 64'(ack), 64'd0);
    adv();
    rst_n = 1'b1;
    chk_cycle();
    check("first_ack_port0", 64'(ack), 64'h1);
    adv();

    // Port 1 read of 0x1000.
    clear_all();
    set_port(1, 1'b1, 1'b0, 15'h1000, 32'h0, 4'hF);
    chk_cycle(); adv();
    clear_all();
    chk_cycle();
    check("p1_read_data", 64'(rd_data), 64'(init_val(15'h1000)));
    adv();

    // Port 2 partial write then immediate read-back.
    set_port(2, 1'b1, 1'b1, 15'h4005, 32'hDEAD_BEEF, 4'b0011);
    chk_cycle(); adv();
    set_port(2, 1'b1, 1'b0, 15'h4005, 32'h0, 4'hF);
    chk_cycle(); adv();
    clear_all();
    chk_cycle();
    iv = init_val(15'h4005);
    check("raw_merge", 64'(rd_data), 64'({iv[31:16], 16'hBEEF}));
    adv();

    // Reset pulsed while a read is in flight.
    set_port(1, 1'b1, 1'b0, 15'h1234, 32'h0, 4'hF);
    chk_cycle(); adv();
    clear_all();
    rst_n = 1'b0;
    chk_cycle();
    check("rst_drop_rdv", 64'(rd_valid), 64'd0);
    adv();
    rst_n = 1'b1;
    chk_cycle();
    check("rst_no_late_rdv", 64'(rd_valid), 64'd0);
    adv();

    // Ports 1..3 held for six cycles.
`ifdef MAIN_RAM_ARB_RR_EN
    seq = '{1, 2, 3, 1, 2, 3};
`else
    seq = '{1, 1, 1, 1, 1, 1};
`endif
    for (int p = 1; p < N; p++) set_port(p, 1'b1, 1'b0, 15'(16'h0300 + p), 32'h0, 4'hF);
    for (int i = 0; i < 6; i++) begin
      chk_cycle();
      check("held_rotation", 64'(ack), 64'(N'(1) << seq[i]));
      adv();
    end

    // Port 0 contending with the rest.
    for (int i = 0; i < 8; i++) begin
      p0 = (i % 3) != 2;
      set_port(0, p0, 1'b0, 15'(16'h0400 + i), 32'h0, 4'hF);
      chk_cycle();
      if (p0) check("p0_override", 64'(ack), 64'h1);
      else    check("p0_absent", 64'(ack[0]), 64'd0);
      adv();
    end

    // Random traffic over a small address window, with occasional reset pulses.
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < N; p++)
        set_port(p, (p == 0) ? ($urandom_range(0, 3) == 0) : 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 15'(16'h0100 + $urandom_range(0, 7)),
                 $urandom, 4'($urandom_range(0, 15)));
      rst_n = ($urandom_range(0, 63) != 0);
      chk_cycle();
      adv();
    end
    rst_n = 1'b1;
    clear_all();
    chk_cycle();
    adv();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
